// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller/checker state encoding and default test geometry.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_EVAL    = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_t;

    localparam int unsigned BIST_WIDTH  = 16;
    localparam logic [15:0] BIST_POLY   = 16'h1021;
    localparam int unsigned BIST_NCLOCK = 650;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left, folds the MSB back through POLY, XORs in din.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(BIST_POLY),
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] r_sig;

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sig <= SEED;
        end else if (load) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= misr_next(r_sig, din);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/bist_signature_checker.sv
// Compacts CUT responses into a MISR under controller handshakes and issues a pass/fail verdict.
module bist_signature_checker
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH  = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(BIST_POLY),
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter logic [WIDTH-1:0] GOLDEN = '0,
    parameter int unsigned      NCLOCK = BIST_NCLOCK
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic                        running,
    input  logic                        finish,
    input  logic [WIDTH-1:0]            resp,
    output logic [WIDTH-1:0]            signature,
    output logic [$clog2(NCLOCK+2)-1:0] count,
    output logic                        done,
    output logic                        pass,
    output logic                        fail
);

    localparam int unsigned           CNT_W    = $clog2(NCLOCK + 2);
    localparam logic [CNT_W-1:0]      NCLOCK_C = CNT_W'(NCLOCK);

    bist_state_t      r_state;
    bist_state_t      w_next;
    logic             w_load;
    logic             w_en;
    logic             w_eval;
    logic             w_match;
    logic [WIDTH-1:0] w_sig;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // init overrides everything; finish only matters while compacting
    always_comb begin
        w_next = r_state;
        if (init) begin
            w_next = ST_COMPACT;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_IDLE;
                ST_COMPACT: w_next = finish ? ST_EVAL : ST_COMPACT;
                ST_EVAL:    w_next = ST_DONE;
                ST_DONE:    w_next = ST_DONE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_load = init;
        w_en   = (r_state == ST_COMPACT) && running && !finish && !init;
        w_eval = (r_state == ST_EVAL) && !init;
    end

    bist_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .en    (w_en),
        .din   (resp),
        .sig   (w_sig)
    );

    // Counter sticks at all-ones so an overrun can never alias back onto NCLOCK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_match = (w_sig == GOLDEN) && (r_count == NCLOCK_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_load) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_eval) begin
            r_done <= 1'b1;
            r_pass <= w_match;
            r_fail <= !w_match;
        end
    end

    assign signature = w_sig;
    assign count     = r_count;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;

endmodule

// File: doc/bist_signature_checker.md
BIST_SIGNATURE_CHECKER -- requirements
Module: bist_signature_checker

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 16, response/signature width
  POLY, 16'h1021, MISR feedback polynomial; bit i set = tap into bit i
  SEED, 16'hFFFF, signature value loaded on init
  GOLDEN, 16'h0000, expected final signature
  NCLOCK, 650, expected number of compacted cycles; same value as the BIST controller
REQ-002 Ports SHALL be, one per line:
  clk  input  1  clock, rising edge
  reset  input  1  asynchronous, active-high
  init  input  1  from controller; start of test, reseed
  running  input  1  from controller; compact resp this cycle
  finish  input  1  from controller; end of test
  resp  input  WIDTH  CUT response word
  signature  output  WIDTH  current MISR contents
  count  output  $clog2(NCLOCK+2)  compacted-cycle counter
  done  output  1  verdict valid
  pass  output  1  signature==GOLDEN and count==NCLOCK
  fail  output  1  verdict valid and not pass

Function
REQ-003 The FSM SHALL have four states: IDLE, COMPACT, EVAL, DONE.
REQ-004 init sampled high in any state SHALL load signature=SEED, clear count/done/pass/fail, and enter COMPACT next cycle.
REQ-005 In COMPACT with running=1, finish=0, init=0: signature SHALL update to {sig[W-2:0],0} ^ (sig[W-1] ? POLY : 0) ^ resp; count SHALL increment.
REQ-006 count SHALL saturate at all-ones and never wrap.
REQ-007 In COMPACT, finish=1 SHALL move to EVAL; that cycle's resp SHALL NOT be compacted even if running=1 (finish wins over running).
REQ-008 EVAL SHALL last exactly one cycle, register pass/fail, assert done, and move to DONE.
REQ-009 done/pass/fail SHALL be valid at the second rising edge after the edge sampling finish; pass and fail SHALL never be 1 together.
REQ-010 DONE SHALL hold signature, count, and verdict until init or reset.
REQ-011 running or finish outside COMPACT SHALL be ignored. init wins over finish when both are high.
REQ-012 In COMPACT with running=0, signature and count SHALL hold.

Reset
REQ-013 reset SHALL take effect asynchronously: state=IDLE, signature=SEED, count=0, done=pass=fail=0.
REQ-014 reset mid-COMPACT or mid-EVAL SHALL abort with no verdict; the next run SHALL require init.

Structure
REQ-015 State encoding, the default WIDTH, POLY, and NCLOCK SHALL live in the shared package bist_pkg, which the controller also uses.
REQ-016 The MISR register and update function SHALL be a sub-module, bist_misr, with ports clk, reset, load, en, din, and sig.

Verification
REQ-017 Reset mid-COMPACT at count=300 -> the same cycle shows done=pass=fail=0, count=0, signature=16'hFFFF; running is then ignored until init.
REQ-018 SEED=0, GOLDEN=0: init, 650 running cycles with resp=0, then finish -> signature=0, count=650; two edges later done=1, pass=1, fail=0.
REQ-019 Same as REQ-018 with resp=16'h0001 on cycle 100 only -> signature nonzero (matches bench model), done=1, fail=1, pass=0.
REQ-020 649 running cycles with GOLDEN equal to the model signature -> fail=1 because count=649.
REQ-021 running and finish high on the same cycle -> count unchanged, resp not compacted; afterwards, init in DONE -> next cycle done=0, signature=SEED, state COMPACT.
